// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_pkg
// Brief    : Shared RISC-V fetch constants and the XLEN width helper.
// Revision : 1.0 - initial release
// ============================================================================
package rv_pkg;

    // Low two bits of a halfword that mark the start of a 32-bit instruction.
    localparam logic [1:0] c_uncompressed = 2'b11;

    function automatic int unsigned xlen(input bit rv64);
        return rv64 ? 32'd64 : 32'd32;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_halfword_queue.sv
`default_nettype none
// ============================================================================
// Module   : rv_halfword_queue
// Brief    : 3-entry 16-bit shift queue; push 1/2, pop 1/2, flush.
// Revision : 1.0 - initial release
// ============================================================================
module rv_halfword_queue (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [1:0]  push_n,
    input  logic [31:0] push_data,
    input  logic [1:0]  pop_n,
    output logic [1:0]  count,
    output logic [31:0] head
);

    logic [2:0][15:0] r_q;
    logic [1:0]       r_count;

    logic [2:0][15:0] w_shift;
    logic [2:0][15:0] w_q_next;
    logic [2:0]       w_base;
    logic [2:0]       w_count_next;

    // Pop first, then append behind whatever survived the pop.
    always_comb begin
        w_shift      = r_q >> {pop_n, 4'b0000};
        w_base       = {1'b0, r_count} - {1'b0, pop_n};
        w_count_next = w_base + {1'b0, push_n};
        w_q_next     = w_shift;
        for (int i = 0; i < 3; i++) begin
            if (push_n != 2'd0 && w_base == i[2:0]) begin
                w_q_next[i] = push_data[15:0];
            end
            if (push_n == 2'd2 && (w_base + 3'd1) == i[2:0]) begin
                w_q_next[i] = push_data[31:16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_q     <= '0;
            r_count <= 2'd0;
        end else begin
            r_q     <= w_q_next;
            r_count <= w_count_next[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            assert (w_count_next <= 3'd3);
            assert (pop_n <= r_count);
        end
    end

    assign count = r_count;
    assign head  = {r_q[1], r_q[0]};

endmodule
`default_nettype wire

// File: rtl/rv_fetch_aligner.sv
`default_nettype none
// ============================================================================
// Module   : rv_fetch_aligner
// Brief    : Turns aligned 32-bit fetch words into whole RV instructions + PC.
// Revision : 1.0 - initial release
// ============================================================================
module rv_fetch_aligner
    import rv_pkg::*;
#(
    parameter bit          rv64     = 1'b1,
    parameter logic [63:0] reset_pc = 64'h0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  redirect_valid,
    input  logic [xlen(rv64)-1:0] redirect_pc,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [xlen(rv64)-1:0] mem_req_addr,
    input  logic                  mem_resp_valid,
    input  logic [31:0]           mem_resp_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_inst,
    output logic [xlen(rv64)-1:0] out_pc
);

    localparam int unsigned            c_xlen       = xlen(rv64);
    localparam logic [c_xlen-1:0]      c_reset_head = {reset_pc[c_xlen-1:1], 1'b0};
    localparam logic [c_xlen-1:0]      c_reset_word = {reset_pc[c_xlen-1:2], 2'b00};
    localparam logic                   c_reset_drop = reset_pc[1];
    localparam logic [c_xlen-1:0]      c_step2      = c_xlen'(2);
    localparam logic [c_xlen-1:0]      c_step4      = c_xlen'(4);

    logic [c_xlen-1:0] r_head_pc;
    logic [c_xlen-1:0] r_fetch_addr;
    logic              r_drop_first;
    logic              r_outstanding;
    logic              r_stale;

    logic [1:0]        w_count;
    logic [31:0]       w_head;
    logic              w_head_compressed;
    logic              w_accept;
    logic              w_resp;
    logic              w_fire;
    logic              w_owed;
    logic [1:0]        w_pop_n;
    logic [1:0]        w_push_n;
    logic [31:0]       w_push_data;
    logic              w_unused_ok;

    assign w_unused_ok = redirect_pc[0];

    rv_halfword_queue u_queue (
        .clk       (clock),
        .rst       (reset),
        .flush     (redirect_valid),
        .push_n    (w_push_n),
        .push_data (w_push_data),
        .pop_n     (w_pop_n),
        .count     (w_count),
        .head      (w_head)
    );

    assign w_head_compressed = (w_head[1:0] != c_uncompressed);

    // Handshake-facing outputs come from registered state; reset only masks them.
    assign mem_req_valid = !reset && !r_outstanding && (w_count <= 2'd1);
    assign mem_req_addr  = r_fetch_addr;
    assign out_valid     = !reset && ((w_count >= 2'd1 && w_head_compressed) || w_count >= 2'd2);
    assign out_pc        = reset ? c_reset_head : r_head_pc;

    always_comb begin
        out_inst = 32'h0;
        if (out_valid) begin
            out_inst = w_head_compressed ? {16'h0, w_head[15:0]} : w_head;
        end
    end

    assign w_accept = mem_req_valid && mem_req_ready;
    assign w_resp   = mem_resp_valid && r_outstanding;
    assign w_fire   = out_valid && out_ready;
    assign w_owed   = w_accept || (r_outstanding && !w_resp);

    always_comb begin
        w_pop_n = 2'd0;
        if (w_fire) begin
            w_pop_n = w_head_compressed ? 2'd1 : 2'd2;
        end
    end

    // A redirect into the upper halfword throws away the low half of the first word.
    always_comb begin
        w_push_n    = 2'd0;
        w_push_data = mem_resp_data;
        if (w_resp && !r_stale) begin
            if (r_drop_first) begin
                w_push_n    = 2'd1;
                w_push_data = {16'h0, mem_resp_data[31:16]};
            end else begin
                w_push_n    = 2'd2;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head_pc     <= c_reset_head;
            r_fetch_addr  <= c_reset_word;
            r_drop_first  <= c_reset_drop;
            r_outstanding <= 1'b0;
            r_stale       <= 1'b0;
        end else begin
            r_outstanding <= w_owed;
            if (redirect_valid) begin
                r_head_pc    <= {redirect_pc[c_xlen-1:1], 1'b0};
                r_fetch_addr <= {redirect_pc[c_xlen-1:2], 2'b00};
                r_drop_first <= redirect_pc[1];
                r_stale      <= w_owed;
            end else begin
                if (w_accept) begin
                    r_fetch_addr <= r_fetch_addr + c_step4;
                end
                if (w_resp) begin
                    r_stale <= 1'b0;
                    if (!r_stale) begin
                        r_drop_first <= 1'b0;
                    end
                end
                if (w_fire) begin
                    r_head_pc <= r_head_pc + (w_head_compressed ? c_step2 : c_step4);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv_fetch_aligner.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_fetch_aligner
// Brief    : Directed bench for rv_fetch_aligner with a small word memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_fetch_aligner;

    localparam logic [63:0] c_reset_pc = 64'h100;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_pc;

    always #5 clock = ~clock;

    rv_fetch_aligner #(
        .rv64     (1'b1),
        .reset_pc (c_reset_pc)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          lat   = 1;
    int          pend_cnt = 0;
    logic [63:0] pend_addr;
    logic [63:0] req_log [$];
    int          idx;
    int          snap;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h0000_0000_0000_0000: return 32'h4501_4505;
            64'h0000_0000_0000_0040: return 32'hDEAD_BEEF;
            64'h0000_0000_0000_0080: return 32'h00B5_0593;
            64'h0000_0000_0000_0100: return 32'h00A5_0513;
            64'h0000_0000_0000_0200: return 32'h0513_ABCD;
            64'h0000_0000_0000_0204: return 32'h1234_00A5;
            64'h0000_0000_0000_0300: return 32'h4585_4505;
            64'h0000_0000_0000_0304: return 32'h4681_4609;
            64'hFFFF_FFFF_FFFF_FFFC: return 32'h4501_4505;
            default:                 return 32'h0001_0001;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        out_ready = 1'b0;
        repeat (n) step();
    endtask

    task automatic redirect(input logic [63:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic take(input string tag, input logic [31:0] inst, input logic [63:0] pc);
        int k = 0;
        while (!out_valid && k < 30) begin
            step();
            k++;
        end
        check_val({tag, "_valid"}, {63'h0, out_valid}, 64'h1);
        check_val({tag, "_inst"}, {32'h0, out_inst}, {32'h0, inst});
        check_val({tag, "_pc"}, out_pc, pc);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    // Memory: one word per accepted request, returned after 'lat' cycles.
    initial begin
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        forever begin
            @(negedge clock);
            mem_resp_valid = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = mem_word(pend_addr);
                end
            end
            if (mem_req_valid && mem_req_ready) begin
                pend_addr = mem_req_addr;
                pend_cnt  = lat;
                req_log.push_back(mem_req_addr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        mem_req_ready  = 1'b1;
        out_ready      = 1'b0;

        // Reset and first fetch from reset_pc
        repeat (3) step();
        check_val("rst_req_valid", {63'h0, mem_req_valid}, 64'h0);
        check_val("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check_val("rst_out_inst", {32'h0, out_inst}, 64'h0);
        check_val("rst_out_pc", out_pc, 64'h100);
        reset = 1'b0;
        #1;
        check_val("c0_req_valid", {63'h0, mem_req_valid}, 64'h1);
        check_val("c0_req_addr", mem_req_addr, 64'h100);
        check_val("c0_out_valid", {63'h0, out_valid}, 64'h0);
        check_val("c0_out_inst", {32'h0, out_inst}, 64'h0);
        check_val("c0_out_pc", out_pc, 64'h100);
        step();
        check_val("c1_out_valid", {63'h0, out_valid}, 64'h0);
        step();
        check_val("c2_nreq", req_log.size(), 64'd1);
        check_val("c2_req0", req_log[0], 64'h100);
        take("t1", 32'h00A5_0513, 64'h100);
        idle(6);

        // Two compressed instructions from one word
        idx = req_log.size();
        redirect(64'h0);
        check_val("t2_req_valid", {63'h0, mem_req_valid}, 64'h1);
        check_val("t2_req_addr", mem_req_addr, 64'h0);
        step();
        check_val("t2_t2_out_valid", {63'h0, out_valid}, 64'h0);
        step();
        check_val("t2_t3_out_valid", {63'h0, out_valid}, 64'h1);
        take("t2_a", 32'h0000_4505, 64'h0);
        check_val("t2_single_fetch", req_log.size() - idx, 64'd1);
        take("t2_b", 32'h0000_4501, 64'h2);
        idle(6);

        // 32-bit instruction straddling a word boundary
        redirect(64'h202);
        check_val("t3_req0_valid", {63'h0, mem_req_valid}, 64'h1);
        check_val("t3_req0_addr", mem_req_addr, 64'h200);
        step();
        step();
        check_val("t3_req1_valid", {63'h0, mem_req_valid}, 64'h1);
        check_val("t3_req1_addr", mem_req_addr, 64'h204);
        check_val("t3_t3_out_valid", {63'h0, out_valid}, 64'h0);
        step();
        check_val("t3_t4_out_valid", {63'h0, out_valid}, 64'h0);
        step();
        check_val("t3_t5_out_valid", {63'h0, out_valid}, 64'h1);
        take("t3", 32'h00A5_0513, 64'h202);
        idle(6);

        // Redirect while a fetch is in flight: its response must be discarded
        lat = 3;
        idx = req_log.size();
        redirect(64'h40);
        check_val("t4_req_valid", {63'h0, mem_req_valid}, 64'h1);
        check_val("t4_req_addr", mem_req_addr, 64'h40);
        step();
        redirect(64'h80);
        check_val("t4_out_valid", {63'h0, out_valid}, 64'h0);
        take("t4", 32'h00B5_0593, 64'h80);
        check_val("t4_log0", req_log[idx], 64'h40);
        check_val("t4_log1", req_log[idx+1], 64'h80);
        lat = 1;
        idle(10);

        // Backpressure with three halfwords buffered
        redirect(64'h300);
        take("t5_a", 32'h0000_4505, 64'h300);
        idle(6);
        snap = req_log.size();
        check_val("t5_req_held", {63'h0, mem_req_valid}, 64'h0);
        check_val("t5_out_valid", {63'h0, out_valid}, 64'h1);
        check_val("t5_inst0", {32'h0, out_inst}, 64'h4585);
        check_val("t5_pc0", out_pc, 64'h302);
        idle(5);
        check_val("t5_no_new_req", req_log.size(), snap);
        check_val("t5_inst1", {32'h0, out_inst}, 64'h4585);
        check_val("t5_pc1", out_pc, 64'h302);
        take("t5_b", 32'h0000_4585, 64'h302);
        take("t5_c", 32'h0000_4609, 64'h304);
        take("t5_d", 32'h0000_4681, 64'h306);
        idle(6);

        // Reset with a response still pending
        lat = 3;
        redirect(64'h500);
        check_val("t6_req_addr", mem_req_addr, 64'h500);
        step();
        reset = 1'b1;
        lat = 1;
        #1;
        check_val("t6_rst_req_valid", {63'h0, mem_req_valid}, 64'h0);
        check_val("t6_rst_out_valid", {63'h0, out_valid}, 64'h0);
        check_val("t6_rst_out_inst", {32'h0, out_inst}, 64'h0);
        check_val("t6_rst_out_pc", out_pc, 64'h100);
        repeat (4) step();
        check_val("t6_rst2_req_valid", {63'h0, mem_req_valid}, 64'h0);
        check_val("t6_rst2_out_pc", out_pc, 64'h100);
        reset = 1'b0;
        #1;
        check_val("t6_c0_req_valid", {63'h0, mem_req_valid}, 64'h1);
        check_val("t6_c0_req_addr", mem_req_addr, 64'h100);
        check_val("t6_c0_out_valid", {63'h0, out_valid}, 64'h0);
        check_val("t6_c0_out_pc", out_pc, 64'h100);
        step();
        step();
        check_val("t6_c2_out_valid", {63'h0, out_valid}, 64'h1);
        take("t6", 32'h00A5_0513, 64'h100);
        idle(6);

        // Fetch address and PC wrap at the top of the address space
        redirect(64'hFFFF_FFFF_FFFF_FFFC);
        take("t7_a", 32'h0000_4505, 64'hFFFF_FFFF_FFFF_FFFC);
        check_val("t7_req_valid", {63'h0, mem_req_valid}, 64'h1);
        check_val("t7_req_addr", mem_req_addr, 64'h0);
        take("t7_b", 32'h0000_4501, 64'hFFFF_FFFF_FFFF_FFFE);
        take("t7_c", 32'h0000_4505, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv_fetch_aligner.md
# rv_fetch_aligner

Fetch-side sequencer that turns a stream of aligned 32-bit memory words into whole RISC-V instructions for `rv_decompressing_decoder`. It tracks the fetch PC, issues word requests, and buffers halfwords so compressed (16-bit) and uncompressed (32-bit) instructions at any 2-byte alignment, including 32-bit instructions straddling a word boundary, reach the decoder as one 32-bit word plus PC. It also handles control-flow redirects and discards in-flight fetches made stale by them.

## Interface
- `rv64`, default 1: XLEN = 64 when 1, 32 when 0; sets the width of every PC/address port.
- `reset_pc`, default 0: PC fetched after reset; bit 0 ignored.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `redirect_valid` in 1: flush and restart fetch at `redirect_pc`.
- `redirect_pc` in XLEN: new PC; bit 0 ignored.
- `mem_req_valid` out 1: word fetch request.
- `mem_req_ready` in 1: memory accepts the request this cycle.
- `mem_req_addr` out XLEN: word address, bits [1:0] always 0.
- `mem_resp_valid` in 1: read data returned, in request order, no earlier than the cycle after acceptance.
- `mem_resp_data` in 32: little-endian word.
- `out_valid` out 1: a complete instruction is presented.
- `out_ready` in 1: consumer (decoder stage) accepts it.
- `out_inst` out 32: instruction; for compressed instructions bits [31:16] are 0.
- `out_pc` out XLEN: PC of `out_inst`, bit 0 always 0.

## Operation
- State: 3-entry halfword queue (`count` 0..3), `head_pc`, `fetch_addr`, `drop_first`, `outstanding`, `stale`.
- Request rule: `mem_req_valid = !outstanding && count <= 1`, derived from registered state only. `mem_req_addr = fetch_addr`.
- On request acceptance: set `outstanding`; `fetch_addr += 4`, wrapping modulo 2^XLEN.
- On response with `stale` set: drop the data and clear `stale` and `outstanding`.
- On response with `stale` clear: enqueue the low halfword then the high halfword. If `drop_first` is set, skip the low halfword and clear `drop_first`. Clear `outstanding`.
- Head is compressed iff `head[1:0] != 2'b11`.
- `out_valid = (count >= 1 && head compressed) || count >= 2`. Registered-state derived; independent of `out_ready` and `redirect_valid`.
- On an out handshake: dequeue 1 halfword (compressed) or 2 (uncompressed); `head_pc += 2` or `+= 4` with wrap.
- Same-cycle dequeue and enqueue: `count_next = count - consumed + added`. The count never exceeds 3 by construction; assert it.
- Redirect has priority over every other update in its cycle:
  - queue emptied; `head_pc = {redirect_pc[XLEN-1:1], 0}`; `fetch_addr = {redirect_pc[XLEN-1:2], 2'b00}`; `drop_first = redirect_pc[1]`.
  - `stale` set iff a response is still owed after this cycle: `outstanding` and no response this cycle, or a request accepted this cycle.
  - An out handshake in the redirect cycle counts as delivered to the consumer; the aligner flushes regardless.
- An unaccepted request may change address after a redirect. The memory side permits withdrawal of unaccepted requests.
- Reset: queue empty, `outstanding = stale = 0`, `head_pc = reset_pc & ~1`, `fetch_addr = reset_pc & ~3`, `drop_first = reset_pc[1]`.

## Timing
- Outputs during the reset cycle and the first cycle after: `out_valid = 0`, `out_inst = 0`, `out_pc = reset_pc & ~1`.
- `mem_req_valid = 0` while reset is asserted; it rises the cycle after reset deasserts.
- With redirect at cycle T, request ready high, response latency 1:
  - request at T+1, response T+2, `out_valid` at T+3.
  - When `redirect_pc[1] = 1` and the instruction is 32-bit: second request T+3, response T+4, `out_valid` T+5.
- At most one outstanding request. Sustained fetch is one word per 2 cycles at latency 1.
- `out_inst`/`out_pc` hold stable while `out_valid && !out_ready`.

## Structure
- Shared package `rv_pkg`: `xlen(rv64)` width function and the `2'b11` uncompressed-marker constant.
- Sub-module `rv_halfword_queue`: 3×16 shift queue with push-1/push-2, pop-1/pop-2 and flush.
- The aligner does not instantiate the decoder; the decoder sits on `out_inst` in the next stage.

## Test plan
- Reset with `reset_pc = 0x100`, word at 0x100 = 0x00A50513 (addi). Required: one request to 0x100, then `out_inst = 0x00A50513`, `out_pc = 0x100`.
- Word 0x4501_4505 at 0x0 (two c.li). Required: two consecutive outputs, `out_inst = 0x4505` then `0x4501`, with `out_pc` 0x0 then 0x2, from a single fetch.
- Redirect to 0x202, word at 0x200 = 0x0513_xxxx, word at 0x204 = 0xxxxx_00A5. Required: fetches to 0x200 and 0x204, then `out_inst = 0x00A50513`, `out_pc = 0x202`.
- Redirect in the cycle after a request to 0x40 is accepted, then redirect to 0x80. Required: the 0x40 response is dropped, and the first `out_pc` is 0x80 with data from 0x80.
- Hold `out_ready = 0` with three halfwords buffered. Required: no new request and output stable; releasing `out_ready` resumes in order.
- Reset asserted mid-fetch with a response pending. Required: all state returns to the reset values, and the next request goes to `reset_pc & ~3`.
